dual_cam_mig_scheduler: RTL and testbench



---
 rtl/dual_cam_mig_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_dual_cam_mig_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_cam_mig_scheduler.sv
// Round-robin MIG command scheduler: two camera write streams, one frame read stream, bounded bursts, capped reads in flight.
// Optional feature macro: DUAL_CAM_READ_SELECT_EN (read_sel_in picks the frame buffer that is read back).
module dual_cam_mig_scheduler #(
    parameter int FRAME_WORDS     = 115200,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         init_calib_complete,
    output logic [26:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    input  logic         app_wdf_rdy,
    output logic [127:0] app_wdf_data,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    output logic [15:0]  app_wdf_mask,
    output logic         app_sr_req,
    output logic         app_ref_req,
    output logic         app_zq_req,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid,
    input  logic [127:0] wr1_data,
    input  logic         wr1_valid,
    input  logic         wr1_tlast,
    output logic         wr1_ready,
    input  logic [127:0] wr2_data,
    input  logic         wr2_valid,
    input  logic         wr2_tlast,
    output logic         wr2_ready,
    output logic [127:0] read_axis_data,
    output logic         read_axis_valid,
    output logic         read_axis_tlast,
    input  logic         read_axis_af,
    input  logic         read_sel_in
);
    localparam int CW = 17;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {S_RST, S_WAIT_INIT, S_ARB, S_RD, S_WR1, S_WR2} state_t;
    typedef enum logic [1:0] {G_RD, G_WR1, G_WR2} grant_t;

    state_t        r_state;
    state_t        w_next;
    grant_t        r_last;
    logic [BW-1:0] r_bcnt;
    logic [CW-1:0] r_wc1, r_wc2, r_rq, r_rs;
    logic [OW-1:0] r_outst;
    logic          r_rd_buf;
    logic          w_rd_elig, w_rd_hs, w_wr1_hs, w_wr2_hs, w_hs, w_sel;
    logic [26:0]   w_rd_word;

    function automatic logic [CW-1:0] f_inc(input logic [CW-1:0] v);
        return (v == LAST_WORD) ? '0 : v + 1'b1;
    endfunction

`ifdef DUAL_CAM_READ_SELECT_EN
    assign w_sel = read_sel_in;
`else
    assign w_sel = 1'b0 & read_sel_in;
`endif

    assign w_rd_elig = (r_outst < OW'(MAX_OUTSTANDING)) && !read_axis_af;
    assign w_rd_hs   = (r_state == S_RD) && w_rd_elig && app_rdy;
    assign w_wr1_hs  = (r_state == S_WR1) && wr1_valid && app_rdy && app_wdf_rdy;
    assign w_wr2_hs  = (r_state == S_WR2) && wr2_valid && app_rdy && app_wdf_rdy;
    assign w_hs      = w_rd_hs || w_wr1_hs || w_wr2_hs;

    // Search starts just after the requester granted last.
    always_comb begin
        w_next = S_ARB;
        case (r_last)
            G_RD: begin
                if (wr1_valid)      w_next = S_WR1;
                else if (wr2_valid) w_next = S_WR2;
                else if (w_rd_elig) w_next = S_RD;
            end
            G_WR1: begin
                if (wr2_valid)      w_next = S_WR2;
                else if (w_rd_elig) w_next = S_RD;
                else if (wr1_valid) w_next = S_WR1;
            end
            default: begin
                if (w_rd_elig)      w_next = S_RD;
                else if (wr1_valid) w_next = S_WR1;
                else if (wr2_valid) w_next = S_WR2;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_RST;
            r_last  <= G_WR2;
            r_bcnt  <= '0;
        end else begin
            case (r_state)
                S_RST:       r_state <= S_WAIT_INIT;
                S_WAIT_INIT: if (init_calib_complete) r_state <= S_ARB;
                S_ARB: begin
                    r_bcnt  <= '0;
                    r_state <= w_next;
                    if (w_next == S_RD)       r_last <= G_RD;
                    else if (w_next == S_WR1) r_last <= G_WR1;
                    else if (w_next == S_WR2) r_last <= G_WR2;
                end
                default: begin
                    if (!app_en) begin
                        r_state <= S_ARB;
                    end else if (w_hs) begin
                        r_bcnt <= r_bcnt + 1'b1;
                        if (r_bcnt == BW'(BURST_LEN - 1)) r_state <= S_ARB;
                    end
                end
            endcase
        end
    end

    // Returns that arrive after a reset still flow out but must not drive the count negative.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wc1    <= '0;
            r_wc2    <= '0;
            r_rq     <= '0;
            r_rs     <= '0;
            r_outst  <= '0;
            r_rd_buf <= 1'b0;
        end else begin
            if (w_wr1_hs) r_wc1 <= wr1_tlast ? '0 : f_inc(r_wc1);
            if (w_wr2_hs) r_wc2 <= wr2_tlast ? '0 : f_inc(r_wc2);
            if (w_rd_hs) begin
                r_rq <= f_inc(r_rq);
                if (r_rq == LAST_WORD) r_rd_buf <= w_sel;
            end
            if (app_rd_data_valid) r_rs <= f_inc(r_rs);
            case ({w_rd_hs, app_rd_data_valid})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   if (r_outst != '0) r_outst <= r_outst - 1'b1;
                default: ;
            endcase
        end
    end

    assign w_rd_word = (r_rd_buf ? 27'(FRAME_WORDS) : 27'd0) + 27'(r_rq);

    always_comb begin
        app_addr     = '0;
        app_cmd      = 3'b000;
        app_wdf_data = '0;
        case (r_state)
            S_RD: begin
                app_addr = w_rd_word << 3;
                app_cmd  = 3'b001;
            end
            S_WR1: begin
                app_addr     = 27'(r_wc1) << 3;
                app_wdf_data = wr1_data;
            end
            S_WR2: begin
                app_addr     = (27'(FRAME_WORDS) + 27'(r_wc2)) << 3;
                app_wdf_data = wr2_data;
            end
            default: ;
        endcase
    end

    assign app_en = ((r_state == S_RD) && w_rd_elig) ||
                    ((r_state == S_WR1) && wr1_valid) ||
                    ((r_state == S_WR2) && wr2_valid);
    assign app_wdf_wren = app_en && ((r_state == S_WR1) || (r_state == S_WR2));
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;
    assign app_sr_req   = 1'b0;
    assign app_ref_req  = 1'b0;
    assign app_zq_req   = 1'b0;
    assign wr1_ready    = app_rdy && app_wdf_rdy && (r_state == S_WR1);
    assign wr2_ready    = app_rdy && app_wdf_rdy && (r_state == S_WR2);

    assign read_axis_data  = app_rd_data;
    assign read_axis_valid = app_rd_data_valid;
    assign read_axis_tlast = app_rd_data_valid && (r_rs == LAST_WORD);
endmodule

// File: tb/tb_dual_cam_mig_scheduler.sv
// Bench for dual_cam_mig_scheduler: cycle table for arbitration, directed corner sequences, randomized traffic vs a transaction-level model.
module tb_dual_cam_mig_scheduler;
    localparam int FW = 48;
    localparam int BL = 16;
    localparam int MO = 8;
`ifdef DUAL_CAM_READ_SELECT_EN
    localparam bit SEL_EN = 1'b1;
`else
    localparam bit SEL_EN = 1'b0;
`endif

    logic         clk, rst_in, init_calib_complete;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy, app_wdf_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren, app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_sr_req, app_ref_req, app_zq_req;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic [127:0] wr1_data, wr2_data;
    logic         wr1_valid, wr1_tlast, wr1_ready, wr2_valid, wr2_tlast, wr2_ready;
    logic [127:0] read_axis_data;
    logic         read_axis_valid, read_axis_tlast, read_axis_af, read_sel_in;

    dual_cam_mig_scheduler #(.FRAME_WORDS(FW), .BURST_LEN(BL), .MAX_OUTSTANDING(MO)) dut (
        .clk_in(clk), .rst_in(rst_in), .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_rdy(app_wdf_rdy), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_sr_req(app_sr_req),
        .app_ref_req(app_ref_req), .app_zq_req(app_zq_req), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .wr1_data(wr1_data), .wr1_valid(wr1_valid),
        .wr1_tlast(wr1_tlast), .wr1_ready(wr1_ready), .wr2_data(wr2_data), .wr2_valid(wr2_valid),
        .wr2_tlast(wr2_tlast), .wr2_ready(wr2_ready), .read_axis_data(read_axis_data),
        .read_axis_valid(read_axis_valid), .read_axis_tlast(read_axis_tlast),
        .read_axis_af(read_axis_af), .read_sel_in(read_sel_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // MIG read-return model: each accepted read comes back lat cycles later, in order.
    int unsigned cyc = 0;
    int unsigned due_q[$];
    int unsigned lat_lo = 2, lat_hi = 2;
    initial begin
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = {$urandom, $urandom, $urandom, $urandom};
                void'(due_q.pop_front());
            end else begin
                app_rd_data_valid = 1'b0;
            end
        end
    end

    // Transaction-level reference: word counters per stream, outstanding reads, read base.
    int m_wc1, m_wc2, m_rq, m_rs, m_out;
    bit m_buf;
    always @(negedge clk) begin
        logic hs1, hs2, hsr;
        if (!rst_in) begin
            m_wc1 = 0; m_wc2 = 0; m_rq = 0; m_rs = 0; m_out = 0; m_buf = 0;
        end else begin
            hs1 = wr1_valid && wr1_ready;
            hs2 = wr2_valid && wr2_ready;
            hsr = app_en && (app_cmd == 3'b001) && app_rdy;
            if (hs1) begin
                chk("wr1_en", app_en, 1'b1);
                chk("wr1_addr", app_addr, 27'(m_wc1 * 8));
                chk("wr1_data", app_wdf_data, wr1_data);
                m_wc1 = wr1_tlast ? 0 : (m_wc1 + 1) % FW;
            end
            if (hs2) begin
                chk("wr2_en", app_en, 1'b1);
                chk("wr2_addr", app_addr, 27'((FW + m_wc2) * 8));
                chk("wr2_data", app_wdf_data, wr2_data);
                m_wc2 = wr2_tlast ? 0 : (m_wc2 + 1) % FW;
            end
            if (app_en && app_cmd == 3'b000 && app_rdy && app_wdf_rdy)
                chk("wr_en_backed", hs1 || hs2, 1'b1);
            chk("wren_end", {app_wdf_wren, app_wdf_end}, {2{app_en && (app_cmd == 3'b000)}});
            chk("ready_excl", wr1_ready && wr2_ready, 1'b0);
            chk("rd_valid_pass", read_axis_valid, app_rd_data_valid);
            chk("rd_data_pass", read_axis_data, app_rd_data);
            chk("rd_tlast", read_axis_tlast, app_rd_data_valid && (m_rs == FW - 1));
            if (app_en && app_cmd == 3'b001)
                chk("rd_eligible", (m_out < MO) && !read_axis_af, 1'b1);
            if (hsr) begin
                chk("rd_addr", app_addr, 27'(((m_buf ? FW : 0) + m_rq) * 8));
                if (m_rq == FW - 1) begin
                    m_rq = 0;
                    m_buf = SEL_EN ? read_sel_in : 1'b0;
                end else begin
                    m_rq++;
                end
                due_q.push_back(cyc + $urandom_range(lat_hi, lat_lo));
            end
            if (app_rd_data_valid) m_rs = (m_rs + 1) % FW;
            if (hsr && !app_rd_data_valid) m_out++;
            else if (!hsr && app_rd_data_valid && m_out > 0) m_out--;
        end
    end

    typedef struct {
        logic        wv1, wv2, rdy;
        logic        en;
        logic [2:0]  cmd;
        logic [26:0] addr;
        logic        r1, r2;
    } vec_t;
    vec_t tbl[42];

    task automatic set_row(input int i, input logic wv1, input logic wv2, input logic rdy,
                           input logic en, input int addr, input logic r1, input logic r2);
        tbl[i].wv1 = wv1; tbl[i].wv2 = wv2; tbl[i].rdy = rdy; tbl[i].en = en;
        tbl[i].cmd = 3'b000; tbl[i].addr = 27'(addr); tbl[i].r1 = r1; tbl[i].r2 = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr1_data = {$urandom, $urandom, $urandom, $urandom};
        wr2_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int ph, cnt, hold;
        bit found;
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ph, cnt, hold;
        bit found;
        rst_in = 1'b0; init_calib_complete = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; read_axis_af = 1'b0; read_sel_in = 1'b0;
        wr1_valid = 1'b0; wr2_valid = 1'b0; wr1_tlast = 1'b0; wr2_tlast = 1'b0;
        wr1_data = '0; wr2_data = '0;

        // Reset values and tied-off outputs
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", app_en, 1'b0);
        chk("rst_addr", app_addr, 27'd0);
        chk("rst_cmd", app_cmd, 3'd0);
        chk("rst_ready", {wr1_ready, wr2_ready, app_wdf_wren, app_wdf_end}, 4'b0);
        chk("tie_offs", {app_wdf_mask, app_sr_req, app_ref_req, app_zq_req}, 19'd0);

        // Calibration gate with every requester eligible
        tick(); rst_in = 1'b1; wr1_valid = 1'b1; wr2_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            @(negedge clk);
            chk("calib_gate_en", {app_en, wr1_ready, wr2_ready}, 3'b0);
        end
        tick(); init_calib_complete = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (app_en) begin found = 1; break; end
        end
        chk("first_grant_seen", found, 1'b1);
        chk("first_grant_cmd", app_cmd, 3'b001);
        chk("first_grant_addr", app_addr, 27'd0);

        // Cycle table: reads blocked, both cameras streaming
        set_row(0, 1, 1, 1, 0, 0, 0, 0);
        set_row(1, 1, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < BL; k++) set_row(2 + k, 1, 1, 1, 1, k * 8, 1, 0);
        set_row(18, 1, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < BL; k++) set_row(19 + k, 1, 1, 1, 1, (FW + k) * 8, 0, 1);
        set_row(35, 1, 1, 1, 0, 0, 0, 0);
        set_row(36, 1, 1, 1, 1, 16 * 8, 1, 0);
        set_row(37, 1, 1, 0, 1, 17 * 8, 0, 0);
        set_row(38, 1, 1, 1, 1, 17 * 8, 1, 0);
        set_row(39, 0, 1, 1, 0, 18 * 8, 1, 0);
        set_row(40, 0, 1, 1, 0, 0, 0, 0);
        set_row(41, 0, 1, 1, 1, (FW + 16) * 8, 0, 1);

        tick(); rst_in = 1'b0; read_axis_af = 1'b1;
        tick();
        tick(); rst_in = 1'b1;
        for (int i = 0; i < 42; i++) begin
            tick();
            wr1_valid = tbl[i].wv1; wr2_valid = tbl[i].wv2; app_rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_en", i), app_en, tbl[i].en);
            chk($sformatf("tbl%0d_cmd", i), app_cmd, tbl[i].cmd);
            chk($sformatf("tbl%0d_addr", i), app_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_ready", i), {wr1_ready, wr2_ready}, {tbl[i].r1, tbl[i].r2});
        end

        // tlast on CAM1 word 37 restarts CAM1; CAM2 keeps its position
        tick(); wr1_valid = 1'b1; wr2_valid = 1'b0;
        ph = 0;
        for (int i = 0; i < 300; i++) begin
            if (i > 0) tick();
            wr1_tlast = 1'b0;
            #1;
            if (ph == 0 && app_en && wr1_ready && app_addr == 27'(37 * 8)) begin
                wr1_tlast = 1'b1; ph = 1;
            end else if (ph == 1 && app_en && wr1_ready) begin
                chk("tlast_restart_addr", app_addr, 27'd0);
                ph = 2;
                break;
            end
        end
        chk("tlast_sequence_done", ph, 2);
        tick(); wr1_valid = 1'b0; wr1_tlast = 1'b0; wr2_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (app_en && wr2_ready) begin found = 1; break; end
        end
        chk("cam2_resume_seen", found, 1'b1);
        chk("cam2_resume_addr", app_addr, 27'((FW + 17) * 8));

        // Outstanding limit with 30-cycle read latency
        tick(); wr2_valid = 1'b0;
        for (int i = 0; i < 200 && due_q.size() > 0; i++) tick();
        lat_lo = 30; lat_hi = 30; read_axis_af = 1'b0;
        cnt = 0; found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (app_rd_data_valid) begin found = 1; break; end
            if (app_en && app_cmd == 3'b001 && app_rdy) cnt++;
        end
        chk("first_return_seen", found, 1'b1);
        chk("reads_before_return", cnt, MO);
        hold = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_out == MO) hold++;
        end
        chk("outstanding_refills", hold > 0, 1'b1);

        // Frame wrap: exactly FW responses between tlasts, then read base selection
        lat_lo = 2; lat_hi = 2; read_sel_in = 1'b1;
        found = 0;
        for (int i = 0; i < 600; i++) begin
            tick(); #1;
            if (read_axis_tlast) begin found = 1; break; end
        end
        chk("tlast_seen", found, 1'b1);
        cnt = 0; found = 0;
        for (int i = 0; i < 600; i++) begin
            tick(); #1;
            if (read_axis_valid) cnt++;
            if (read_axis_tlast) begin found = 1; break; end
        end
        chk("frame_len_between_tlast", {found, 31'(cnt)}, {1'b1, 31'(FW)});
        for (int s = 0; s < 2; s++) begin
            read_sel_in = (s == 0);
            ph = 0;
            for (int i = 0; i < 600; i++) begin
                tick(); #1;
                if (app_en && app_cmd == 3'b001 && app_rdy) begin
                    if (ph == 1) begin
                        chk($sformatf("wrap_sel%0d_addr", read_sel_in), app_addr,
                            (read_sel_in && SEL_EN) ? 27'(FW * 8) : 27'd0);
                        ph = 2;
                        break;
                    end
                    if (m_rq == FW - 1) ph = 1;
                end
            end
            chk("wrap_seen", ph, 2);
        end

        // Asynchronous reset in the middle of a CAM2 burst
        tick(); read_axis_af = 1'b1; wr2_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (app_en && wr2_ready) begin found = 1; break; end
        end
        chk("wr2_burst_seen", found, 1'b1);
        #2 rst_in = 1'b0;
        #1;
        chk("async_rst_outputs", {app_en, wr2_ready, app_wdf_wren}, 3'b0);
        tick(); init_calib_complete = 1'b0; read_axis_af = 1'b0;
        tick();
        tick(); rst_in = 1'b1;
        repeat (5) tick();
        init_calib_complete = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (app_en) begin found = 1; break; end
        end
        chk("post_rst_first_cmd", {found, app_cmd}, {1'b1, 3'b001});
        chk("post_rst_rd_addr", app_addr, 27'd0);
        tick(); read_axis_af = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (app_en && wr2_ready) begin found = 1; break; end
        end
        chk("post_rst_wr2_seen", found, 1'b1);
        chk("post_rst_wr2_addr", app_addr, 27'(FW * 8));

        // Randomized traffic against the reference model
        lat_lo = 1; lat_hi = 25;
        for (int i = 0; i < 3000; i++) begin
            tick();
            wr1_valid = ($urandom_range(99) < 60);
            wr2_valid = ($urandom_range(99) < 60);
            wr1_tlast = ($urandom_range(99) < 3);
            wr2_tlast = ($urandom_range(99) < 3);
            read_axis_af = ($urandom_range(99) < 20);
            app_rdy = ($urandom_range(99) < 80);
            app_wdf_rdy = ($urandom_range(99) < 85);
            read_sel_in = $urandom_range(1);
        end
        tick();
        wr1_valid = 1'b0; wr2_valid = 1'b0; read_axis_af = 1'b1;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
